// File: rtl/if_stage_sram_q.sv
// if_stage_sram_q: LoongArch fetch stage over a req/addr_ok/data_ok SRAM with an in-order fetch queue.
module if_stage_sram_q #(
  parameter logic [31:0] PC_RESET = 32'h1C000000,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  input  logic        wb_ex,
  input  logic        wb_ertn,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0][31:0] pc_q, pc_d, inst_q, inst_d;
  logic [DEPTH-1:0] adef_q, adef_d, done_q, done_d;
  logic [AW-1:0] head_q, head_d, tail, fill;
  logic [CNT_W-1:0] cnt_q, cnt_d, cancel_q, cancel_d, occ, nd;
  logic [31:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d, redir_pc;
  logic held_q, pend_q, pend_d, stall_q, stall_d;
  logic redir, can_go, hs, adef_push, push, pop, found, dok_drop, dok_fill;
  assign redir = wb_ex | wb_ertn | br_bus[32];
  assign redir_pc = wb_ex ? csr_eentry : wb_ertn ? csr_era : br_bus[31:0];
  assign occ = cnt_q + cancel_q;
  assign can_go = !reset && occ < CNT_W'(DEPTH) && !stall_q;
  // a request shown without addr_ok stays up (same address) until accepted
  assign inst_sram_req = held_q || (can_go && fetch_pc_q[1:0] == 2'b00);
  assign inst_sram_addr = fetch_pc_q;
  assign hs = inst_sram_req && inst_sram_addr_ok;
  assign adef_push = !held_q && can_go && fetch_pc_q[1:0] != 2'b00 && !redir;
  assign push = hs && !pend_q && !redir;
  assign fs_to_ds_valid = cnt_q != '0 && done_q[head_q];
  assign fs_to_ds_bus = fs_to_ds_valid ? {adef_q[head_q], inst_q[head_q], pc_q[head_q]} : '0;
  assign pop = fs_to_ds_valid && ds_allowin && !redir;
  assign tail = head_q + cnt_q[AW-1:0];
  assign dok_drop = inst_sram_data_ok && cancel_q != '0;
  assign dok_fill = inst_sram_data_ok && cancel_q == '0 && found;
  always_comb begin
    found = 1'b0;
    fill = head_q;
    nd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < cnt_q && !done_q[head_q + AW'(i)]) begin
        nd = nd + CNT_W'(1);
        if (!found) fill = head_q + AW'(i);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    pc_d = pc_q;
    inst_d = inst_q;
    adef_d = adef_q;
    done_d = done_q;
    head_d = head_q + AW'(pop);
    cnt_d = cnt_q + CNT_W'(push | adef_push) - CNT_W'(pop);
    cancel_d = cancel_q - CNT_W'(dok_drop) + CNT_W'(hs && pend_q && !redir);
    fetch_pc_d = push ? fetch_pc_q + 32'd4 : (hs && pend_q) ? pend_pc_q : fetch_pc_q;
    pend_pc_d = pend_pc_q;
    pend_d = pend_q && !hs;
    stall_d = stall_q | adef_push;
    if (dok_fill) begin
      inst_d[fill] = inst_sram_rdata;
      done_d[fill] = 1'b1;
    end
    if (push | adef_push) begin
      pc_d[tail] = fetch_pc_q;
      adef_d[tail] = adef_push;
      inst_d[tail] = '0;
      done_d[tail] = adef_push;
    end
    // a fill landing this cycle is no longer outstanding, so it is not cancelled
    if (redir) begin
      cnt_d = '0;
      cancel_d = cancel_q - CNT_W'(dok_drop) + nd - CNT_W'(dok_fill) + CNT_W'(hs);
      stall_d = 1'b0;
      fetch_pc_d = (inst_sram_req && !hs) ? fetch_pc_q : redir_pc;
      pend_d = inst_sram_req && !hs;
      pend_pc_d = redir_pc;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      inst_q <= '0;
      adef_q <= '0;
      done_q <= '0;
      head_q <= '0;
      cnt_q <= '0;
      cancel_q <= '0;
      fetch_pc_q <= PC_RESET;
      pend_pc_q <= '0;
      pend_q <= 1'b0;
      stall_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inst_q <= inst_d;
      adef_q <= adef_d;
      done_q <= done_d;
      head_q <= head_d;
      cnt_q <= cnt_d;
      cancel_q <= cancel_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q <= pend_d;
      stall_q <= stall_d;
      held_q <= inst_sram_req && !inst_sram_addr_ok;
    end
  end
endmodule

// File: tb/tb_if_stage_sram_q.sv
// tb_if_stage_sram_q: randomized fetch-stage bench against a queue-based reference model.
module tb_if_stage_sram_q;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, ds_allowin = 0, wb_ex = 0, wb_ertn = 0;
  logic [32:0] br_bus = '0;
  logic [31:0] csr_eentry = '0, csr_era = '0, inst_sram_rdata = '0, inst_sram_addr;
  logic inst_sram_addr_ok = 0, inst_sram_data_ok = 0, inst_sram_req, fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  always #5 clk = ~clk;
  if_stage_sram_q #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus), .wb_ex(wb_ex),
    .wb_ertn(wb_ertn), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata));
  typedef struct {logic [31:0] pc; logic adef; logic [31:0] inst; logic done;} ent_t;
  ent_t mq[$];
  logic [31:0] sq[$], hs_log[$];
  logic [64:0] del_log[$];
  int mcancel, n_cmp = 0, n_bad = 0, p_aok, p_dok, p_allow, p_redir;
  logic [31:0] mpc, mpend_pc;
  logic mheld, mpend, mstall;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C96E1;
  endfunction
  function automatic logic exp_req();
    return !reset && (mheld || (mq.size() + mcancel < DEPTH && !mstall && mpc[1:0] == 2'b00));
  endfunction
  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare_all();
    logic ev;
    ev = !reset && mq.size() > 0 && mq[0].done;
    chk("req", inst_sram_req, exp_req());
    if (exp_req()) chk("addr", inst_sram_addr, mpc);
    chk("valid", fs_to_ds_valid, ev);
    if (ev) chk("bus", fs_to_ds_bus, {mq[0].adef, mq[0].inst, mq[0].pc});
  endtask
  task automatic model_step();
    logic hs, rd, ev, ereq, filled;
    logic [31:0] tgt;
    int nd, occ;
    if (reset) return;
    ereq = exp_req();
    ev = mq.size() > 0 && mq[0].done;
    occ = mq.size() + mcancel;
    hs = ereq && inst_sram_addr_ok;
    rd = wb_ex || wb_ertn || br_bus[32];
    tgt = wb_ex ? csr_eentry : wb_ertn ? csr_era : br_bus[31:0];
    if (hs) begin
      sq.push_back(mpc);
      hs_log.push_back(mpc);
    end
    if (inst_sram_data_ok) begin
      void'(sq.pop_front());
      if (mcancel > 0) mcancel--;
      else begin
        filled = 0;
        for (int i = 0; i < mq.size(); i++)
          if (!filled && !mq[i].done) begin
            mq[i].inst = inst_sram_rdata;
            mq[i].done = 1;
            filled = 1;
          end
      end
    end
    if (rd) begin
      nd = 0;
      foreach (mq[i]) if (!mq[i].done) nd++;
      mcancel += nd + int'(hs);
      mq.delete();
      mstall = 0;
      if (hs) begin mpc = tgt; mpend = 0; end
      else if (ereq) begin mpend = 1; mpend_pc = tgt; end
      else mpc = tgt;
    end else begin
      if (ev && ds_allowin) begin
        del_log.push_back({mq[0].adef, mq[0].inst, mq[0].pc});
        void'(mq.pop_front());
      end
      if (hs) begin
        if (mpend) begin mcancel++; mpc = mpend_pc; mpend = 0; end
        else begin mq.push_back('{pc: mpc, adef: 1'b0, inst: 32'h0, done: 1'b0}); mpc += 4; end
      end else if (!mheld && occ < DEPTH && !mstall && mpc[1:0] != 2'b00) begin
        mq.push_back('{pc: mpc, adef: 1'b1, inst: 32'h0, done: 1'b1});
        mstall = 1;
      end
    end
    mheld = ereq && !inst_sram_addr_ok;
  endtask
  function automatic logic [31:0] rnd_tgt();
    return 32'h1C000000 | ($urandom_range(255) << 2) | (($urandom_range(7) == 0) ? $urandom_range(3, 1) : 0);
  endfunction
  task automatic drive();
    inst_sram_addr_ok = $urandom_range(99) < p_aok;
    inst_sram_data_ok = sq.size() > 0 && $urandom_range(99) < p_dok;
    inst_sram_rdata = inst_sram_data_ok ? mem(sq[0]) : $urandom;
    ds_allowin = $urandom_range(99) < p_allow;
    csr_eentry = rnd_tgt();
    csr_era = rnd_tgt();
    br_bus = {1'b0, rnd_tgt()};
    wb_ex = 0;
    wb_ertn = 0;
    if ($urandom_range(99) < p_redir) begin
      wb_ex = $urandom_range(3) == 0;
      wb_ertn = $urandom_range(2) == 0;
      br_bus[32] = !(wb_ex || wb_ertn) || $urandom_range(1) == 1;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic cyc();
    drive();
    tick();
  endtask
  task automatic do_reset();
    reset = 1;
    {wb_ex, wb_ertn, inst_sram_addr_ok, inst_sram_data_ok, ds_allowin} = '0;
    br_bus = '0;
    mq.delete(); sq.delete();
    mcancel = 0; mpc = 32'h1C000000; mpend_pc = '0; mheld = 0; mpend = 0; mstall = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", inst_sram_req, 1'b0);
    chk("rst_valid", fs_to_ds_valid, 1'b0);
    chk("rst_bus", fs_to_ds_bus, 65'h0);
    reset = 0;
    #1 compare_all();
    hs_log.delete(); del_log.delete();
  endtask
  initial begin
    p_redir = 0;
    // sequential stream with single-cycle data return
    do_reset();
    p_aok = 100; p_dok = 100; p_allow = 100;
    chk("d1_first_addr", inst_sram_addr, 32'h1C000000);
    repeat (8) cyc();
    chk("d1_hs0", hs_log[0], 32'h1C000000);
    chk("d1_hs1", hs_log[1], 32'h1C000004);
    chk("d1_hs2", hs_log[2], 32'h1C000008);
    chk("d1_del0", del_log[0], {1'b0, mem(32'h1C000000), 32'h1C000000});
    chk("d1_del1", del_log[1], {1'b0, mem(32'h1C000004), 32'h1C000004});
    // fill to DEPTH with ID stalled, then drain
    do_reset();
    p_allow = 0;
    repeat (10) cyc();
    chk("d2_hs_cnt", hs_log.size(), 4);
    chk("d2_req_full", inst_sram_req, 1'b0);
    p_allow = 100;
    cyc();
    chk("d2_one_pop", del_log.size(), 1);
    chk("d2_req_resume", inst_sram_req, 1'b1);
    // branch with three outstanding fetches
    do_reset();
    p_aok = 100; p_dok = 0;
    cyc(); cyc();
    drive(); br_bus = {1'b1, 32'h1C000100}; tick();
    chk("d3_cancel", mcancel, 3);
    chk("d3_req", inst_sram_req, 1'b1);
    chk("d3_addr", inst_sram_addr, 32'h1C000100);
    cyc();
    p_aok = 0; p_dok = 100;
    repeat (3) cyc();
    chk("d3_dropped", fs_to_ds_valid, 1'b0);
    repeat (3) cyc();
    chk("d3_ndel", del_log.size(), 1);
    chk("d3_pc", del_log[0][31:0], 32'h1C000100);
    // exception while a request is held
    do_reset();
    p_aok = 0; p_dok = 100;
    cyc();
    drive(); wb_ex = 1; csr_eentry = 32'h1C008000; tick();
    chk("d4_hold1", inst_sram_addr, 32'h1C000000);
    cyc();
    chk("d4_hold2", inst_sram_addr, 32'h1C000000);
    p_aok = 100; cyc();
    chk("d4_new_addr", inst_sram_addr, 32'h1C008000);
    cyc(); p_aok = 0;
    repeat (5) cyc();
    chk("d4_ndel", del_log.size(), 1);
    chk("d4_pc", del_log[0][31:0], 32'h1C008000);
    // redirect priority
    do_reset();
    p_aok = 100;
    drive(); wb_ex = 1; csr_eentry = 32'h1C008000; br_bus = {1'b1, 32'h1C000200}; tick();
    chk("d5_prio", inst_sram_addr, 32'h1C008000);
    // misaligned target raises ADEF and stalls
    do_reset();
    p_allow = 0;
    drive(); br_bus = {1'b1, 32'h1C000102}; tick();
    chk("d6_no_req", inst_sram_req, 1'b0);
    repeat (3) cyc();
    chk("d6_stall", inst_sram_req, 1'b0);
    chk("d6_valid", fs_to_ds_valid, 1'b1);
    chk("d6_bus", fs_to_ds_bus, {1'b1, 32'h0, 32'h1C000102});
    drive(); wb_ex = 1; csr_eentry = 32'h1C008000; tick();
    chk("d6_req", inst_sram_req, 1'b1);
    chk("d6_addr", inst_sram_addr, 32'h1C008000);
    // randomized traffic with a mid-run reset
    p_aok = 60; p_dok = 50; p_allow = 70; p_redir = 4;
    do_reset();
    repeat (2000) cyc();
    do_reset();
    p_aok = 80; p_dok = 70; p_allow = 40; p_redir = 6;
    repeat (2000) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_stage_sram_q.md
Name: if_stage_sram_q

Overview:
- Next-generation instruction-fetch stage for the LoongArch pipeline.
- Replaces the fixed single-cycle SRAM read with a req/addr_ok/data_ok split-transaction interface.
- Holds up to DEPTH fetches in flight or buffered in an in-order queue; requests cancelled by a redirect are discarded as their data returns.
- Sits between the redirect sources (WB exception/ertn, ID branch) and the ID stage.

Parameters:
- PC_RESET, 32'h1C000000, first fetch address after reset.
- DEPTH, 4, queue entries (power of 2, ≥2); caps issued-but-unconsumed fetches.
- CNT_W, $clog2(DEPTH)+1, width of occupancy/cancel counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ds_allowin  in  1  ID accepts the head entry this cycle.
- br_bus  in  33  {br_taken, br_target[31:0]}; br_taken is a one-cycle pulse.
- wb_ex  in  1  exception redirect pulse.
- wb_ertn  in  1  ertn redirect pulse.
- csr_eentry  in  32  exception target.
- csr_era  in  32  ertn target.
- fs_to_ds_valid  out  1  head entry valid.
- fs_to_ds_bus  out  65  {adef, inst[31:0], pc[31:0]}.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  32  fetch address.
- inst_sram_addr_ok  in  1  request accepted; handshake completes when req && addr_ok.
- inst_sram_data_ok  in  1  read data valid; responses return in request order.
- inst_sram_rdata  in  32  instruction word.

Behaviour:
- Reset (async): fetch_pc=PC_RESET, queue empty, cancel_cnt=0, pend_redir=0. Outputs: req=0, fs_to_ds_valid=0, bus=0.
- Redirect: priority wb_ex > wb_ertn > br_taken. Target is csr_eentry / csr_era / br_target.
- Queue entry fields: pc, adef, inst, done.
- Occupancy = queue entries + cancel_cnt. Both counters are CNT_W wide and saturate only at DEPTH.
- Issue condition: req=1 when occupancy<DEPTH and no adef entry is already queued, with addr=fetch_pc.
- Once req=1 without addr_ok, req and addr are held stable until addr_ok, even across a redirect.
- Handshake (req && addr_ok): push {pc=fetch_pc, adef=0, done=0}; fetch_pc+=4. Wrap-around modulo 2^32.
- ADEF: if fetch_pc[1:0]!=0, no request is issued. Push {pc, adef=1, inst=0, done=1} once, then stall fetch until a redirect.
- data_ok:
  - If cancel_cnt>0: decrement cancel_cnt and drop rdata.
  - Else: write rdata into the oldest entry with done=0 and set done.
  - data_ok with nothing outstanding is a protocol error; ignore it.
- Output: fs_to_ds_valid = head valid && head.done. On the same cycle the data_ok that completes the head is registered, the head is not yet visible; visibility is one cycle later.
- Pop: on fs_to_ds_valid && ds_allowin.
- Redirect with no request held:
  - Queue cleared.
  - cancel_cnt += count of entries with done=0 that have been handshaked.
  - fetch_pc = target; req may issue to the target the next cycle.
- Redirect while a request is held:
  - Queue cleared and cancel_cnt updated as above.
  - The held request also adds +1 to cancel_cnt when it handshakes.
  - Target latched in pend_redir; fetch_pc = target after that handshake.
  - A later redirect before that handshake overwrites pend_redir.
- Same-cycle events with a redirect:
  - Pop: ignored.
  - data_ok: applied first. A done entry is then cleared; if it targeted a cancelled request, cancel_cnt is decremented before the redirect adds to it.
- Full: occupancy==DEPTH → req=0. Pop and issue in the same cycle are allowed only if occupancy<DEPTH before the pop.
- Redirect during reset has no effect. Reset mid-transaction discards all state; the SRAM side is reset together.

Test Plan:
- Reset release, addr_ok=1, data_ok one cycle after each handshake, ds_allowin=1 → addrs 1C000000, 1C000004, 1C000008… Bus pcs in order with matching rdata, adef=0.
- ds_allowin=0, DEPTH=4, addr_ok=1, data_ok immediate → exactly 4 handshakes, then req=0. Raise ds_allowin → one pop per cycle and req resumes.
- 3 outstanding (no data_ok), br_taken with target 1C000100 → cancel_cnt=3, next req addr=1C000100. The next 3 data_ok are dropped; the 4th yields pc=1C000100.
- req held with addr_ok=0, wb_ex=1 with eentry 1C008000 → addr unchanged until addr_ok; that response is dropped; next req addr=1C008000.
- Same cycle wb_ex (eentry 1C008000) and br_taken (target 1C000200) → next addr 1C008000.
- br_target=1C000102 → no req issued; bus={adef=1, inst=0, pc=1C000102}; fetch stalls until a wb_ex redirect.
